// File: rtl/ucycle_strobe_gen.sv
// ucycle_strobe_gen
//   Microcycle sequencer for the microcode decoders. Produces the one-hot,
//   active-low time strobes tn[NPH:1] that clock the 1w/3w/10w decoder
//   registers. It also issues the microword load strobe, supports run,
//   single-step and halt, and stretches phase WAIT_PH with wait states while
//   a RAM/tape operation is busy.
//
// Ports
//   main_clk    in   main clock, all state changes on the rising edge
//   resn        in   asynchronous active-low reset
//   run         in   level, free-running microcycles
//   step        in   pulse, runs exactly one microcycle when idle
//   halt_req    in   level, stop at the end of the current microcycle
//   mem_op      in   current microword performs a RAM/tape operation
//   ram_busy    in   RAM/tape not ready, extends phase WAIT_PH
//   err_clr     in   clears timeout_err
//   tn          out  time strobes, tn[k]=0 during phase k, all 1 when idle
//   uw_ld       out  1 during phase NPH (latch next microword)
//   cyc_start   out  1 during phase 1
//   cyc_end     out  1 during phase NPH
//   running     out  1 whenever not idle
//   wait_st     out  1 during inserted wait clocks
//   timeout_err out  sticky, a wait reached WAIT_MAX clocks
//   cyc_cnt     out  completed microcycle count (wraps)
module ucycle_strobe_gen #(
    parameter int NPH      = 10,
    parameter int WAIT_PH  = 6,
    parameter int WAIT_MAX = 255
) (
    input  logic           main_clk,
    input  logic           resn,
    input  logic           run,
    input  logic           step,
    input  logic           halt_req,
    input  logic           mem_op,
    input  logic           ram_busy,
    input  logic           err_clr,
    output logic [NPH:1]   tn,
    output logic           uw_ld,
    output logic           cyc_start,
    output logic           cyc_end,
    output logic           running,
    output logic           wait_st,
    output logic           timeout_err,
    output logic [15:0]    cyc_cnt
);

    localparam int PW = $clog2(NPH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PH,
        ST_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [7:0]     wait_cnt_q, wait_cnt_d;
    logic           step_prev_q;
    logic           timeout_err_q, timeout_err_d;
    logic [15:0]    cyc_cnt_q, cyc_cnt_d;
    logic [NPH:1]   tn_q, tn_d;
    logic           uw_ld_q, uw_ld_d;
    logic           cyc_start_q, cyc_start_d;
    logic           cyc_end_q, cyc_end_d;
    logic           running_q, running_d;
    logic           wait_st_q, wait_st_d;

    logic           step_edge;
    logic           leave_phase;
    logic           timeout_set;

    // A step that is held high only counts once: starting needs a fresh
    // rising edge, so a long or repeated pulse cannot chain extra cycles.
    assign step_edge = step & ~step_prev_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        wait_cnt_d  = wait_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        leave_phase = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run || step_edge) begin
                    state_d = ST_PH;
                    phase_d = PW'(1);
                end
            end
            ST_PH: begin
                if (phase_q == PW'(WAIT_PH) && mem_op && ram_busy) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd0;
                end else begin
                    leave_phase = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!ram_busy) begin
                    leave_phase = 1'b1;
                end else if (wait_cnt_q == 8'(WAIT_MAX - 1)) begin
                    // This is wait clock number WAIT_MAX: give up and move on.
                    leave_phase = 1'b1;
                    timeout_set = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase

        if (leave_phase) begin
            wait_cnt_d = 8'd0;
            if (phase_q == PW'(NPH)) begin
                cyc_cnt_d = cyc_cnt_q + 16'd1;
                if (run && !halt_req) begin
                    state_d = ST_PH;
                    phase_d = PW'(1);
                end else begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end
            end else begin
                state_d = ST_PH;
                phase_d = phase_q + PW'(1);
            end
        end

        // Setting wins over clearing when both happen in the same clock.
        timeout_err_d = timeout_set | (timeout_err_q & ~err_clr);

        // Strobes are decoded from the next state so the registered outputs
        // line up exactly with the state they describe.
        for (int k = 1; k <= NPH; k++) begin
            tn_d[k] = !((state_d != ST_IDLE) && (phase_d == PW'(k)));
        end
        running_d   = (state_d != ST_IDLE);
        wait_st_d   = (state_d == ST_WAIT);
        cyc_start_d = (state_d == ST_PH) && (phase_d == PW'(1));
        uw_ld_d     = (state_d == ST_PH) && (phase_d == PW'(NPH));
        cyc_end_d   = uw_ld_d;
    end

    always_ff @(posedge main_clk or negedge resn) begin
        if (!resn) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            wait_cnt_q    <= 8'd0;
            step_prev_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            cyc_cnt_q     <= 16'd0;
            tn_q          <= '1;
            uw_ld_q       <= 1'b0;
            cyc_start_q   <= 1'b0;
            cyc_end_q     <= 1'b0;
            running_q     <= 1'b0;
            wait_st_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            wait_cnt_q    <= wait_cnt_d;
            step_prev_q   <= step;
            timeout_err_q <= timeout_err_d;
            cyc_cnt_q     <= cyc_cnt_d;
            tn_q          <= tn_d;
            uw_ld_q       <= uw_ld_d;
            cyc_start_q   <= cyc_start_d;
            cyc_end_q     <= cyc_end_d;
            running_q     <= running_d;
            wait_st_q     <= wait_st_d;
        end
    end

    assign tn          = tn_q;
    assign uw_ld       = uw_ld_q;
    assign cyc_start   = cyc_start_q;
    assign cyc_end     = cyc_end_q;
    assign running     = running_q;
    assign wait_st     = wait_st_q;
    assign timeout_err = timeout_err_q;
    assign cyc_cnt     = cyc_cnt_q;

endmodule

// File: tb/tb_ucycle_strobe_gen.sv
// Directed testbench for ucycle_strobe_gen (NPH=10, WAIT_PH=6, WAIT_MAX=255).
module tb_ucycle_strobe_gen;

    logic        main_clk;
    logic        resn;
    logic        run;
    logic        step;
    logic        halt_req;
    logic        mem_op;
    logic        ram_busy;
    logic        err_clr;
    logic [10:1] tn;
    logic        uw_ld;
    logic        cyc_start;
    logic        cyc_end;
    logic        running;
    logic        wait_st;
    logic        timeout_err;
    logic [15:0] cyc_cnt;

    int checks = 0;
    int errors = 0;

    ucycle_strobe_gen #(.NPH(10), .WAIT_PH(6), .WAIT_MAX(255)) dut (
        .main_clk    (main_clk),
        .resn        (resn),
        .run         (run),
        .step        (step),
        .halt_req    (halt_req),
        .mem_op      (mem_op),
        .ram_busy    (ram_busy),
        .err_clr     (err_clr),
        .tn          (tn),
        .uw_ld       (uw_ld),
        .cyc_start   (cyc_start),
        .cyc_end     (cyc_end),
        .running     (running),
        .wait_st     (wait_st),
        .timeout_err (timeout_err),
        .cyc_cnt     (cyc_cnt)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    task automatic tick();
        @(posedge main_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] strobe(input int k);
        logic [9:0] one;
        one = 10'd1;
        return ~(one << (k - 1));
    endfunction

    initial begin
        int clks;
        int uw_cnt;
        int tn6_cnt;
        int ws_cnt;
        int busy_left;
        logic seen_ph7;

        resn = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        mem_op = 1'b0; ram_busy = 1'b0; err_clr = 1'b0;
        tick(); tick();
        chk("rst_tn", 32'(tn), 32'h3FF);
        chk("rst_running", 32'(running), 0);
        chk("rst_cyc_cnt", 32'(cyc_cnt), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        resn = 1'b1;
        tick();
        chk("idle_tn", 32'(tn), 32'h3FF);

        // Single step, walking strobes; a second step pulse mid-cycle is ignored.
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("step_tn_ph%0d", k), 32'(tn), 32'(strobe(k)));
            chk($sformatf("step_cs_ph%0d", k), 32'(cyc_start), (k == 1) ? 32'd1 : 32'd0);
            chk($sformatf("step_uwld_ph%0d", k), 32'(uw_ld), (k == 10) ? 32'd1 : 32'd0);
            chk($sformatf("step_cend_ph%0d", k), 32'(cyc_end), (k == 10) ? 32'd1 : 32'd0);
            step = (k == 3);
            tick();
        end
        step = 1'b0;
        chk("step_end_tn", 32'(tn), 32'h3FF);
        chk("step_end_running", 32'(running), 0);
        chk("step_end_cyc_cnt", 32'(cyc_cnt), 1);
        tick();
        chk("step_stays_idle", 32'(running), 0);

        // Free run for 3 cycles, halt requested in PH3 of the 4th.
        run = 1'b1;
        tick();
        clks = 0; uw_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (!running) break;
            clks++;
            if (uw_ld) uw_cnt++;
            if (uw_cnt == 3 && tn[3] == 1'b0) halt_req = 1'b1;
            tick();
        end
        run = 1'b0; halt_req = 1'b0;
        chk("run_clks", 32'(clks), 40);
        chk("run_uwld_pulses", 32'(uw_cnt), 4);
        chk("run_cyc_cnt", 32'(cyc_cnt), 5);
        chk("run_idle_tn", 32'(tn), 32'h3FF);

        // Memory op with ram_busy high for 5 clocks starting in PH6.
        mem_op = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        clks = 0; tn6_cnt = 0; ws_cnt = 0; busy_left = 5;
        for (int i = 0; i < 60; i++) begin
            if (!running) break;
            clks++;
            if (tn[6] == 1'b0) tn6_cnt++;
            if (wait_st) ws_cnt++;
            if (tn[6] == 1'b0 && busy_left > 0) begin
                ram_busy = 1'b1;
                busy_left--;
            end else begin
                ram_busy = 1'b0;
            end
            tick();
        end
        ram_busy = 1'b0;
        chk("wait_clks", 32'(clks), 15);
        chk("wait_tn6_low", 32'(tn6_cnt), 6);
        chk("wait_st_clks", 32'(ws_cnt), 5);
        chk("wait_cyc_cnt", 32'(cyc_cnt), 6);
        chk("wait_no_timeout", 32'(timeout_err), 0);

        // mem_op=0: ram_busy must be ignored.
        mem_op = 1'b0; ram_busy = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        clks = 0; ws_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (!running) break;
            clks++;
            if (wait_st) ws_cnt++;
            tick();
        end
        chk("nomem_clks", 32'(clks), 10);
        chk("nomem_wait_st", 32'(ws_cnt), 0);
        chk("nomem_cyc_cnt", 32'(cyc_cnt), 7);

        // ram_busy stuck: timeout after 255 waits, err_clr held high throughout
        // so the set/clear collision and the following clear are both seen.
        mem_op = 1'b1; ram_busy = 1'b1; err_clr = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        clks = 0; tn6_cnt = 0; ws_cnt = 0; seen_ph7 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!running) break;
            clks++;
            if (tn[6] == 1'b0) tn6_cnt++;
            if (wait_st) ws_cnt++;
            if (tn[7] == 1'b0) begin
                seen_ph7 = 1'b1;
                chk("tmo_set_wins_clr", 32'(timeout_err), 1);
            end
            if (tn[8] == 1'b0) chk("tmo_cleared", 32'(timeout_err), 0);
            tick();
        end
        chk("tmo_reached_ph7", 32'(seen_ph7), 1);
        chk("tmo_wait_clks", 32'(ws_cnt), 255);
        chk("tmo_tn6_low", 32'(tn6_cnt), 256);
        chk("tmo_total_clks", 32'(clks), 265);
        chk("tmo_cyc_cnt", 32'(cyc_cnt), 8);

        // Timeout again without err_clr: sticky until cleared.
        err_clr = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!running) break;
            tick();
        end
        chk("tmo_sticky_idle", 32'(timeout_err), 1);
        tick();
        chk("tmo_sticky_hold", 32'(timeout_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("tmo_err_clr", 32'(timeout_err), 0);
        mem_op = 1'b0; ram_busy = 1'b0;

        // Counter wrap from 0xFFFF.
        force dut.cyc_cnt_q = 16'hFFFF;
        tick();
        release dut.cyc_cnt_q;
        tick();
        chk("wrap_preload", 32'(cyc_cnt), 32'hFFFF);
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("wrap_cyc_end", 32'(cyc_end), 1);
        chk("wrap_before", 32'(cyc_cnt), 32'hFFFF);
        tick();
        chk("wrap_after", 32'(cyc_cnt), 0);

        // Asynchronous reset in PH4 of a running cycle.
        run = 1'b1;
        tick();
        tick(); tick(); tick();
        chk("pre_rst_ph4", 32'(tn), 32'(strobe(4)));
        #2;
        resn = 1'b0;
        #1;
        chk("async_rst_tn", 32'(tn), 32'h3FF);
        chk("async_rst_running", 32'(running), 0);
        chk("async_rst_cyc_cnt", 32'(cyc_cnt), 0);
        run = 1'b0;
        tick();
        resn = 1'b1;
        tick();
        chk("post_rst_idle", 32'(running), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
